// File: rtl/axi4_reg_slice.sv
// AXI4 register slice: one configurable buffer per channel (AW, W, B, AR, R) to break
// timing paths between an upstream master port (S_) and a downstream slave port (M_).

package axi4_reg_slice_pkg;

    localparam int unsigned MODE_BYPASS  = 0;
    localparam int unsigned MODE_FORWARD = 1;
    localparam int unsigned MODE_FULL    = 2;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } slice_state_e;

endpackage

// Single-channel valid/ready buffer; payload is opaque and passes through unchanged.
module axi4_reg_slice_ch
    import axi4_reg_slice_pkg::*;
#(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned MODE  = MODE_FULL
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_s_valid,
    output logic             o_s_ready,
    input  logic [WIDTH-1:0] i_s_data,
    output logic             o_m_valid,
    input  logic             i_m_ready,
    output logic [WIDTH-1:0] o_m_data,
    output logic             o_idle
);

    if (MODE == MODE_BYPASS) begin : g_bypass
        assign o_m_valid = i_s_valid;
        assign o_m_data  = i_s_data;
        assign o_s_ready = i_m_ready;
        assign o_idle    = 1'b1;

        logic w_unused;
        assign w_unused = ^{i_clk, i_rst_n};

    end else if (MODE == MODE_FORWARD) begin : g_forward
        logic             r_flag;
        logic [WIDTH-1:0] r_data;
        logic             w_s_hs;

        // A full register can still accept when the sink drains it in the same cycle.
        assign o_s_ready = ~r_flag | i_m_ready;
        assign w_s_hs    = i_s_valid & o_s_ready;

        // NOTE: sequential state uses non-blocking assignments so every register samples
        // the pre-edge values, independent of statement order.
        always_ff @(posedge i_clk) begin
            if (!i_rst_n)       r_flag <= 1'b0;
            else if (w_s_hs)    r_flag <= 1'b1;
            else if (i_m_ready) r_flag <= 1'b0;
        end

        // NOTE: payload registers carry no reset; the valid flag alone qualifies them.
        always_ff @(posedge i_clk) begin
            if (w_s_hs) r_data <= i_s_data;
        end

        assign o_m_valid = r_flag;
        assign o_m_data  = r_flag ? r_data : '0;
        assign o_idle    = ~r_flag;

    end else begin : g_full
        slice_state_e     r_state;
        slice_state_e     w_state_nxt;
        logic             r_s_ready;
        logic [WIDTH-1:0] r_main;
        logic [WIDTH-1:0] r_skid;
        logic             w_s_hs;
        logic             w_m_hs;

        assign w_s_hs = i_s_valid & r_s_ready;
        assign w_m_hs = (r_state != ST_EMPTY) & i_m_ready;

        // Ready is registered from the next state so no combinational path crosses the slice.
        always_ff @(posedge i_clk) begin
            if (!i_rst_n) begin
                r_state   <= ST_EMPTY;
                r_s_ready <= 1'b0;
            end else begin
                r_state   <= w_state_nxt;
                r_s_ready <= (w_state_nxt != ST_TWO);
            end
        end

        // NOTE: the default assignment up front keeps this block from inferring a latch.
        always_comb begin
            w_state_nxt = r_state;
            case (r_state)
                ST_EMPTY: if (w_s_hs) w_state_nxt = ST_ONE;
                ST_ONE: begin
                    if (w_s_hs && !w_m_hs)      w_state_nxt = ST_TWO;
                    else if (!w_s_hs && w_m_hs) w_state_nxt = ST_EMPTY;
                end
                ST_TWO:   if (w_m_hs) w_state_nxt = ST_ONE;
                default:  w_state_nxt = ST_EMPTY;
            endcase
        end

        always_ff @(posedge i_clk) begin
            if (r_state == ST_TWO) begin
                if (w_m_hs) r_main <= r_skid;
            end else if (w_s_hs) begin
                if (r_state == ST_ONE && !w_m_hs) r_skid <= i_s_data;
                else                              r_main <= i_s_data;
            end
        end

        always_comb begin
            o_m_valid = (r_state != ST_EMPTY);
            o_m_data  = (r_state != ST_EMPTY) ? r_main : '0;
            o_s_ready = r_s_ready;
            o_idle    = (r_state == ST_EMPTY);
        end
    end

endmodule

module axi4_reg_slice #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ID_WIDTH   = 4,
    parameter int unsigned LEN_WIDTH  = 8,
    parameter int unsigned AW_MODE    = 2,
    parameter int unsigned W_MODE     = 2,
    parameter int unsigned B_MODE     = 2,
    parameter int unsigned AR_MODE    = 2,
    parameter int unsigned R_MODE     = 2
) (
    input  logic                    ACLK,
    input  logic                    ARESETn,
    input  logic [ID_WIDTH-1:0]     S_AWID,
    input  logic [ADDR_WIDTH-1:0]   S_AWADDR,
    input  logic [LEN_WIDTH-1:0]    S_AWLEN,
    input  logic [2:0]              S_AWSIZE,
    input  logic [1:0]              S_AWBURST,
    input  logic                    S_AWVALID,
    output logic                    S_AWREADY,
    output logic [ID_WIDTH-1:0]     M_AWID,
    output logic [ADDR_WIDTH-1:0]   M_AWADDR,
    output logic [LEN_WIDTH-1:0]    M_AWLEN,
    output logic [2:0]              M_AWSIZE,
    output logic [1:0]              M_AWBURST,
    output logic                    M_AWVALID,
    input  logic                    M_AWREADY,
    input  logic [DATA_WIDTH-1:0]   S_WDATA,
    input  logic [DATA_WIDTH/8-1:0] S_WSTRB,
    input  logic                    S_WLAST,
    input  logic                    S_WVALID,
    output logic                    S_WREADY,
    output logic [DATA_WIDTH-1:0]   M_WDATA,
    output logic [DATA_WIDTH/8-1:0] M_WSTRB,
    output logic                    M_WLAST,
    output logic                    M_WVALID,
    input  logic                    M_WREADY,
    input  logic [ID_WIDTH-1:0]     M_BID,
    input  logic [1:0]              M_BRESP,
    input  logic                    M_BVALID,
    output logic                    M_BREADY,
    output logic [ID_WIDTH-1:0]     S_BID,
    output logic [1:0]              S_BRESP,
    output logic                    S_BVALID,
    input  logic                    S_BREADY,
    input  logic [ID_WIDTH-1:0]     S_ARID,
    input  logic [ADDR_WIDTH-1:0]   S_ARADDR,
    input  logic [LEN_WIDTH-1:0]    S_ARLEN,
    input  logic [2:0]              S_ARSIZE,
    input  logic [1:0]              S_ARBURST,
    input  logic                    S_ARVALID,
    output logic                    S_ARREADY,
    output logic [ID_WIDTH-1:0]     M_ARID,
    output logic [ADDR_WIDTH-1:0]   M_ARADDR,
    output logic [LEN_WIDTH-1:0]    M_ARLEN,
    output logic [2:0]              M_ARSIZE,
    output logic [1:0]              M_ARBURST,
    output logic                    M_ARVALID,
    input  logic                    M_ARREADY,
    input  logic [ID_WIDTH-1:0]     M_RID,
    input  logic [DATA_WIDTH-1:0]   M_RDATA,
    input  logic [1:0]              M_RRESP,
    input  logic                    M_RLAST,
    input  logic                    M_RVALID,
    output logic                    M_RREADY,
    output logic [ID_WIDTH-1:0]     S_RID,
    output logic [DATA_WIDTH-1:0]   S_RDATA,
    output logic [1:0]              S_RRESP,
    output logic                    S_RLAST,
    output logic                    S_RVALID,
    input  logic                    S_RREADY,
    output logic                    IDLE
);

    localparam int unsigned AX_W = ID_WIDTH + ADDR_WIDTH + LEN_WIDTH + 5;
    localparam int unsigned WD_W = DATA_WIDTH + DATA_WIDTH / 8 + 1;
    localparam int unsigned BR_W = ID_WIDTH + 2;
    localparam int unsigned RD_W = ID_WIDTH + DATA_WIDTH + 3;

    logic w_aw_idle, w_w_idle, w_b_idle, w_ar_idle, w_r_idle;

    axi4_reg_slice_ch #(.WIDTH(AX_W), .MODE(AW_MODE)) u_aw (
        .i_clk(ACLK), .i_rst_n(ARESETn),
        .i_s_valid(S_AWVALID), .o_s_ready(S_AWREADY),
        .i_s_data({S_AWID, S_AWADDR, S_AWLEN, S_AWSIZE, S_AWBURST}),
        .o_m_valid(M_AWVALID), .i_m_ready(M_AWREADY),
        .o_m_data({M_AWID, M_AWADDR, M_AWLEN, M_AWSIZE, M_AWBURST}),
        .o_idle(w_aw_idle)
    );

    axi4_reg_slice_ch #(.WIDTH(WD_W), .MODE(W_MODE)) u_w (
        .i_clk(ACLK), .i_rst_n(ARESETn),
        .i_s_valid(S_WVALID), .o_s_ready(S_WREADY),
        .i_s_data({S_WDATA, S_WSTRB, S_WLAST}),
        .o_m_valid(M_WVALID), .i_m_ready(M_WREADY),
        .o_m_data({M_WDATA, M_WSTRB, M_WLAST}),
        .o_idle(w_w_idle)
    );

    // Response channels flow from the M_ side back to the S_ side.
    axi4_reg_slice_ch #(.WIDTH(BR_W), .MODE(B_MODE)) u_b (
        .i_clk(ACLK), .i_rst_n(ARESETn),
        .i_s_valid(M_BVALID), .o_s_ready(M_BREADY),
        .i_s_data({M_BID, M_BRESP}),
        .o_m_valid(S_BVALID), .i_m_ready(S_BREADY),
        .o_m_data({S_BID, S_BRESP}),
        .o_idle(w_b_idle)
    );

    axi4_reg_slice_ch #(.WIDTH(AX_W), .MODE(AR_MODE)) u_ar (
        .i_clk(ACLK), .i_rst_n(ARESETn),
        .i_s_valid(S_ARVALID), .o_s_ready(S_ARREADY),
        .i_s_data({S_ARID, S_ARADDR, S_ARLEN, S_ARSIZE, S_ARBURST}),
        .o_m_valid(M_ARVALID), .i_m_ready(M_ARREADY),
        .o_m_data({M_ARID, M_ARADDR, M_ARLEN, M_ARSIZE, M_ARBURST}),
        .o_idle(w_ar_idle)
    );

    axi4_reg_slice_ch #(.WIDTH(RD_W), .MODE(R_MODE)) u_r (
        .i_clk(ACLK), .i_rst_n(ARESETn),
        .i_s_valid(M_RVALID), .o_s_ready(M_RREADY),
        .i_s_data({M_RID, M_RDATA, M_RRESP, M_RLAST}),
        .o_m_valid(S_RVALID), .i_m_ready(S_RREADY),
        .o_m_data({S_RID, S_RDATA, S_RRESP, S_RLAST}),
        .o_idle(w_r_idle)
    );

    assign IDLE = &{w_aw_idle, w_w_idle, w_b_idle, w_ar_idle, w_r_idle};

endmodule

// File: doc/axi4_reg_slice.md
Name: axi4_reg_slice

Overview:
- Parametrised AXI4 register slice inserted between an AXI4 master port (S_ side) and a slave port (M_ side) to break timing paths on all five channels (AW, W, B, AR, R).
- Buffering mode is chosen per channel: bypass, forward-registered, or full two-entry skid.
- Bus widths are shared with the project's AXI interface.
- Used inside the VIP's DUT wrappers and as a reusable fabric block.

Parameters:
ADDR_WIDTH, 32, address width
DATA_WIDTH, 32, data width; WSTRB width is DATA_WIDTH/8
ID_WIDTH, 4, ID width on AW/B/AR/R
LEN_WIDTH, 8, burst length width
AW_MODE, 2, 0=bypass 1=forward 2=full (same encoding for all *_MODE)
W_MODE, 2, W channel mode
B_MODE, 2, B channel mode
AR_MODE, 2, AR channel mode
R_MODE, 2, R channel mode

Ports:
ACLK  in  1  clock; all logic on posedge
ARESETn  in  1  synchronous, active-low reset
S_AWID/S_AWADDR/S_AWLEN/S_AWSIZE/S_AWBURST, S_AWVALID  in  ID/ADDR/LEN/3/2, 1  upstream AW payload and valid; S_AWREADY out 1
M_AWID..M_AWBURST, M_AWVALID  out  same widths  downstream AW; M_AWREADY in 1
S_WDATA/S_WSTRB/S_WLAST, S_WVALID  in  DATA/DATA/8/1, 1  upstream W; S_WREADY out 1
M_WDATA/M_WSTRB/M_WLAST, M_WVALID  out  same  downstream W; M_WREADY in 1
M_BID/M_BRESP, M_BVALID  in  ID/2, 1  downstream B; M_BREADY out 1
S_BID/S_BRESP, S_BVALID  out  ID/2, 1  upstream B; S_BREADY in 1
S_ARID..S_ARBURST, S_ARVALID  in  as AW  upstream AR; S_ARREADY out 1
M_ARID..M_ARBURST, M_ARVALID  out  as AW  downstream AR; M_ARREADY in 1
M_RID/M_RDATA/M_RRESP/M_RLAST, M_RVALID  in  ID/DATA/2/1, 1  downstream R; M_RREADY out 1
S_RID/S_RDATA/S_RRESP/S_RLAST, S_RVALID  out  same  upstream R; S_RREADY in 1
IDLE  out  1  all non-bypass slices empty

Behaviour:
- One identical slice per channel. Source side drives VALID, sink side drives READY; B and R flow M_ to S_. Handshake = VALID & READY at a posedge.
- Bypass (0): all signals wired straight through. Zero latency, no state.
- Forward (1): single payload register with a valid flag.
  - Sink VALID = flag.
  - Source READY = ~flag | sink READY (combinational ready path).
  - Latency 1 cycle. Full throughput.
- Full (2): states EMPTY, ONE, TWO, with main and skid registers.
  - Source READY is registered: 1 in EMPTY and ONE, 0 in TWO.
  - Sink VALID = (state != EMPTY); sink payload always comes from main.
  - EMPTY: source handshake -> ONE, load main.
  - ONE:
    - source and sink handshakes together -> ONE, reload main.
    - source handshake only -> TWO, load skid.
    - sink handshake only -> EMPTY.
  - TWO: sink handshake -> ONE, main <= skid. Source cannot handshake in TWO.
  - Latency 1 cycle. Sustains 1 beat/cycle with no combinational path in either direction.
- Order is preserved on every channel. No beats are dropped or duplicated.
- Slices do not interpret payload: WLAST/RLAST/IDs pass unchanged, and no burst splitting or reordering is performed.
- Output stability: once sink VALID=1 it stays 1, with payload stable, until the sink handshake. Sink READY deasserting mid-burst only stalls.
- Reset:
  - While ARESETn=0 at a posedge, all slices go to EMPTY / flag=0.
  - All M_*VALID/S_*VALID outputs of non-bypass slices are 0. All registered READY outputs are 0.
  - IDLE=1.
  - Registered READYs rise at the first posedge with ARESETn=1.
  - Payload registers are not reset, but never appear while VALID=0 (drive 0 while empty so benches see no X).
- Reset mid-operation: buffered beats are discarded at that edge, with no partial-state retention. Upstream is responsible for re-issuing.
- IDLE = AND over non-bypass channels of (state==EMPTY / flag==0). Registered-state decode, no dependence on inputs.
- Simultaneous AW and W traffic: channels are fully independent, and W may precede AW as in AXI4.

Test Plan:
- Full mode, AW: drive AWADDR=0x1000,0x1004,0x1008 back-to-back with M_AWREADY=1 -> M_AWVALID from cycle+1, addresses in order, one per cycle, S_AWREADY constantly 1.
- Full mode, W backpressure: 4-beat burst WDATA=0xA0..0xA3, WLAST on 0xA3; hold M_WREADY=0 cycles 2-5 -> S_WREADY drops exactly after 2 beats buffered (TWO), M_W payload 0xA0 stable, all 4 beats delivered in order with WLAST only on 0xA3.
- Forward mode, R: M_RVALID with RID=3, RDATA=0xDEADBEEF, S_RREADY=0 -> S_RVALID=1 next cycle holding data; S_RREADY=1 -> single transfer, M_RREADY combinationally follows S_RREADY when full.
- Bypass B: BID=5, BRESP=2'b10 -> S_B* equals M_B* same cycle, M_BREADY==S_BREADY.
- Reset mid-burst: two AR beats buffered (TWO), assert ARESETn=0 one cycle -> next edge M_ARVALID=0, S_ARREADY=0, IDLE=1; after release S_ARREADY=1 one edge later, no stale beat emitted.
- Random valid/ready toggling on all five channels, 10k cycles, scoreboard per channel -> zero loss/duplication/reorder, VALID-stability assertion never fires.
